// File: rtl/sfx_scheduler_pkg.sv
// Shared constants for the sound-effect scheduler: effect ids, FSM states, note frequencies
// (also used by the bgm players) and small helpers.
package sfx_scheduler_pkg;

  typedef logic [25:0] tone_t;

  localparam tone_t REST_TONE_HZ = 26'd20000;

  typedef enum logic [1:0] {
    SFX_JUMP  = 2'd0,
    SFX_COIN  = 2'd1,
    SFX_HIT   = 2'd2,
    SFX_DEATH = 2'd3
  } sfx_id_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } sched_state_e;

  localparam tone_t NOTE_C4 = 26'd262;
  localparam tone_t NOTE_G4 = 26'd392;
  localparam tone_t NOTE_C5 = 26'd523;
  localparam tone_t NOTE_D5 = 26'd587;
  localparam tone_t NOTE_E5 = 26'd659;
  localparam tone_t NOTE_F5 = 26'd698;
  localparam tone_t NOTE_G5 = 26'd784;
  localparam tone_t NOTE_B5 = 26'd988;
  localparam tone_t NOTE_E6 = 26'd1319;

  // Highest set bit wins; bit 3 is the most important effect.
  function automatic logic [1:0] top_bit(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

  // The divider stage cannot take 0 Hz, so rests become an inaudible tone.
  function automatic tone_t audible(input tone_t t, input tone_t rest);
    return (t == '0) ? rest : t;
  endfunction

endpackage

// File: rtl/sfx_rom.sv
// Note patterns for the four effects; a tone of 0 is a rest, last marks the final note.
module sfx_rom
  import sfx_scheduler_pkg::*;
(
  input  logic [4:0]  addr,
  output logic [25:0] tone,
  output logic        last
);

  always_comb begin
    tone = '0;
    last = 1'b1;
    case (addr)
      {SFX_JUMP,  3'd0}: begin tone = NOTE_C5; last = 1'b0; end
      {SFX_JUMP,  3'd1}: begin tone = NOTE_E5; last = 1'b0; end
      {SFX_JUMP,  3'd2}: begin tone = NOTE_G5; last = 1'b1; end
      {SFX_COIN,  3'd0}: begin tone = NOTE_B5; last = 1'b0; end
      {SFX_COIN,  3'd1}: begin tone = NOTE_E6; last = 1'b1; end
      {SFX_HIT,   3'd0}: begin tone = NOTE_C4; last = 1'b0; end
      {SFX_HIT,   3'd1}: begin tone = '0;      last = 1'b0; end
      {SFX_HIT,   3'd2}: begin tone = NOTE_C4; last = 1'b1; end
      // The death jingle fills all slots and ends through index saturation.
      {SFX_DEATH, 3'd0}: begin tone = NOTE_G5; last = 1'b0; end
      {SFX_DEATH, 3'd1}: begin tone = NOTE_F5; last = 1'b0; end
      {SFX_DEATH, 3'd2}: begin tone = NOTE_E5; last = 1'b0; end
      {SFX_DEATH, 3'd3}: begin tone = NOTE_D5; last = 1'b0; end
      {SFX_DEATH, 3'd4}: begin tone = NOTE_C5; last = 1'b0; end
      {SFX_DEATH, 3'd5}: begin tone = '0;      last = 1'b0; end
      {SFX_DEATH, 3'd6}: begin tone = NOTE_G4; last = 1'b0; end
      {SFX_DEATH, 3'd7}: begin tone = NOTE_C4; last = 1'b0; end
      default:           begin tone = '0;      last = 1'b1; end
    endcase
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Shares the stereo tone path between BGM and four prioritised one-shot effects,
// with preemption, request queueing and a fixed-rate note sequencer.
module sfx_scheduler
  import sfx_scheduler_pkg::*;
#(
  parameter int    TICK_DIV   = 6_250_000,
  parameter int    NOTE_TICKS = 2,
  parameter int    MAX_NOTES  = 8,
  parameter tone_t REST_TONE  = REST_TONE_HZ
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mute,
  input  logic [25:0] bgm_l,
  input  logic [25:0] bgm_r,
  input  logic [3:0]  sfx_req,
  output logic [25:0] toneL,
  output logic [25:0] toneR,
  output logic        sfx_busy,
  output logic [1:0]  sfx_id,
  output logic        sfx_done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int NW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;

  sched_state_e   state_q, state_d;
  logic [3:0]     pending_q, pending_d;
  logic [1:0]     id_q, id_d;
  logic [2:0]     note_q, note_d;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [NW-1:0]  tick_num_q, tick_num_d;
  logic [25:0]    tone_l_q, tone_l_d;
  logic [25:0]    tone_r_q, tone_r_d;
  logic           done_q, done_d;

  logic [25:0] rom_tone;
  logic        rom_last;
  logic [3:0]  pend_n;
  logic [1:0]  win;
  logic        tick_end, note_end, is_last, preempt, start;

  sfx_rom u_rom (
    .addr (5'({id_q, note_q})),
    .tone (rom_tone),
    .last (rom_last)
  );

  always_comb begin
    pend_n   = pending_q | sfx_req;
    win      = top_bit(pend_n);
    tick_end = (tick_cnt_q == TW'(TICK_DIV - 1));
    note_end = tick_end && (tick_num_q == NW'(NOTE_TICKS - 1));
    is_last  = rom_last || (note_q == 3'(MAX_NOTES - 1));
    preempt  = (pend_n != 4'd0) && (win > id_q);

    state_d    = state_q;
    pending_d  = pend_n;
    id_d       = id_q;
    note_d     = note_q;
    tick_cnt_d = tick_end ? '0 : tick_cnt_q + 1'b1;
    tick_num_d = tick_end ? (note_end ? '0 : tick_num_q + 1'b1) : tick_num_q;
    done_d     = 1'b0;
    start      = 1'b0;

    case (state_q)
      ST_IDLE: start = (pend_n != 4'd0);
      ST_PLAY: begin
        // Preemption wins over a natural finish in the same cycle, so no done pulse.
        if (preempt) begin
          start = 1'b1;
        end else if (note_end) begin
          if (is_last) begin
            done_d = 1'b1;
            if (pend_n != 4'd0) begin
              start = 1'b1;
            end else begin
              state_d = ST_IDLE;
              id_d    = 2'd0;
              note_d  = 3'd0;
            end
          end else begin
            note_d = note_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d    = ST_PLAY;
      id_d       = win;
      note_d     = 3'd0;
      tick_cnt_d = '0;
      tick_num_d = '0;
      pending_d  = pend_n & ~(4'b0001 << win);
    end

    if (mute) begin
      tone_l_d = REST_TONE;
      tone_r_d = REST_TONE;
    end else if (state_q == ST_PLAY) begin
      tone_l_d = audible(rom_tone, REST_TONE);
      tone_r_d = audible(rom_tone, REST_TONE);
    end else begin
      tone_l_d = audible(bgm_l, REST_TONE);
      tone_r_d = audible(bgm_r, REST_TONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= 4'd0;
      id_q       <= 2'd0;
      note_q     <= 3'd0;
      tick_cnt_q <= '0;
      tick_num_q <= '0;
      tone_l_q   <= REST_TONE;
      tone_r_q   <= REST_TONE;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      id_q       <= id_d;
      note_q     <= note_d;
      tick_cnt_q <= tick_cnt_d;
      tick_num_q <= tick_num_d;
      tone_l_q   <= tone_l_d;
      tone_r_q   <= tone_r_d;
      done_q     <= done_d;
    end
  end

  assign toneL    = tone_l_q;
  assign toneR    = tone_r_q;
  assign sfx_busy = (state_q == ST_PLAY);
  assign sfx_id   = id_q;
  assign sfx_done = done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Scoreboard bench for sfx_scheduler at TICK_DIV=4, NOTE_TICKS=2 (8 cycles per note).
module tb_sfx_scheduler;

  localparam logic [25:0] REST = 26'd20000;

  typedef struct packed {
    logic [25:0] tl;
    logic [25:0] tr;
    logic        busy;
    logic [1:0]  id;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mute = 1'b0;
  logic [25:0] bgm_l = '0;
  logic [25:0] bgm_r = '0;
  logic [3:0]  sfx_req = '0;
  logic [25:0] toneL, toneR;
  logic        sfx_busy, sfx_done;
  logic [1:0]  sfx_id;

  int n_checks = 0;
  int n_fail = 0;

  exp_t        sb[$];
  logic [25:0] src_l = REST;
  logic [25:0] src_r = REST;
  bit          done_next = 1'b0;

  int notes [4][8] = '{
    '{523, 659, 784, 0, 0, 0, 0, 0},
    '{988, 1319, 0, 0, 0, 0, 0, 0},
    '{262, 0, 262, 0, 0, 0, 0, 0},
    '{784, 698, 659, 587, 523, 0, 392, 262}
  };

  sfx_scheduler #(
    .TICK_DIV   (4),
    .NOTE_TICKS (2),
    .MAX_NOTES  (8),
    .REST_TONE  (26'd20000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mute     (mute),
    .bgm_l    (bgm_l),
    .bgm_r    (bgm_r),
    .sfx_req  (sfx_req),
    .toneL    (toneL),
    .toneR    (toneR),
    .sfx_busy (sfx_busy),
    .sfx_id   (sfx_id),
    .sfx_done (sfx_done)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] hz(input logic [25:0] v);
    return (v == 0) ? REST : v;
  endfunction

  // Outputs are registered: the tone seen in a cycle comes from the state of the previous one.
  task automatic push_state(input logic busy, input logic [1:0] id,
                            input logic [25:0] nl, input logic [25:0] nr);
    exp_t e;
    e.tl = src_l; e.tr = src_r; e.busy = busy; e.id = id; e.done = done_next;
    done_next = 1'b0;
    sb.push_back(e);
    src_l = nl; src_r = nr;
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) push_state(1'b0, 2'd0, hz(bgm_l), hz(bgm_r));
  endtask

  task automatic push_effect(input int id, input int ncyc, input bit natural);
    logic [25:0] t;
    for (int k = 0; k < ncyc; k++) begin
      t = hz(26'(notes[id][k / 8]));
      push_state(1'b1, 2'(id), t, t);
    end
    if (natural) done_next = 1'b1;
  endtask

  task automatic mute_window(input int a, input int b);
    exp_t t;
    for (int c = a; c <= b; c++) begin
      t = sb[c]; t.tl = REST; t.tr = REST; sb[c] = t;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    src_l = REST; src_r = REST; done_next = 1'b0;
    push_idle(7);
    for (int c = 0; sb.size() > 0; c++) begin
      rst = (c < 3); sfx_req = (c < 3) ? 4'hF : 4'h0;
      @(posedge clk); #1;
      e = sb.pop_front(); n_checks++;
      if ({toneL, toneR, sfx_busy, sfx_id, sfx_done} !== e) begin
        n_fail++;
        $display("FAIL reset c%0d: got tl=%0d tr=%0d busy=%0b id=%0d done=%0b, want tl=%0d tr=%0d busy=%0b id=%0d done=%0b",
                 c, toneL, toneR, sfx_busy, sfx_id, sfx_done, e.tl, e.tr, e.busy, e.id, e.done);
      end
    end
  endtask

  task automatic test_passthrough();
    exp_t e;
    bgm_l = 26'd440; bgm_r = 26'd0;
    src_l = hz(bgm_l); src_r = hz(bgm_r);
    push_idle(3);
    for (int c = 0; sb.size() > 0; c++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); n_checks++;
      if ({toneL, toneR, sfx_busy, sfx_id, sfx_done} !== e) begin
        n_fail++;
        $display("FAIL passthrough c%0d: got tl=%0d tr=%0d busy=%0b id=%0d done=%0b, want tl=%0d tr=%0d busy=%0b id=%0d done=%0b",
                 c, toneL, toneR, sfx_busy, sfx_id, sfx_done, e.tl, e.tr, e.busy, e.id, e.done);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    push_effect(0, 24, 1'b1);
    push_idle(3);
    for (int c = 0; sb.size() > 0; c++) begin
      sfx_req = (c == 0) ? 4'b0001 : 4'b0000;
      @(posedge clk); #1;
      e = sb.pop_front(); n_checks++;
      if ({toneL, toneR, sfx_busy, sfx_id, sfx_done} !== e) begin
        n_fail++;
        $display("FAIL single c%0d: got tl=%0d tr=%0d busy=%0b id=%0d done=%0b, want tl=%0d tr=%0d busy=%0b id=%0d done=%0b",
                 c, toneL, toneR, sfx_busy, sfx_id, sfx_done, e.tl, e.tr, e.busy, e.id, e.done);
      end
    end
  endtask

  task automatic test_preempt();
    exp_t e;
    push_effect(1, 6, 1'b0);
    push_effect(3, 64, 1'b1);
    push_idle(2);
    for (int c = 0; sb.size() > 0; c++) begin
      sfx_req = (c == 0) ? 4'b0010 : (c == 6) ? 4'b1000 : 4'b0000;
      @(posedge clk); #1;
      e = sb.pop_front(); n_checks++;
      if ({toneL, toneR, sfx_busy, sfx_id, sfx_done} !== e) begin
        n_fail++;
        $display("FAIL preempt c%0d: got tl=%0d tr=%0d busy=%0b id=%0d done=%0b, want tl=%0d tr=%0d busy=%0b id=%0d done=%0b",
                 c, toneL, toneR, sfx_busy, sfx_id, sfx_done, e.tl, e.tr, e.busy, e.id, e.done);
      end
    end
  endtask

  task automatic test_queueing();
    exp_t e;
    push_effect(3, 64, 1'b1);
    push_effect(1, 16, 1'b1);
    push_effect(0, 24, 1'b1);
    push_idle(2);
    for (int c = 0; sb.size() > 0; c++) begin
      sfx_req = (c == 0) ? 4'b1000 : (c == 3) ? 4'b0011 : 4'b0000;
      @(posedge clk); #1;
      e = sb.pop_front(); n_checks++;
      if ({toneL, toneR, sfx_busy, sfx_id, sfx_done} !== e) begin
        n_fail++;
        $display("FAIL queueing c%0d: got tl=%0d tr=%0d busy=%0b id=%0d done=%0b, want tl=%0d tr=%0d busy=%0b id=%0d done=%0b",
                 c, toneL, toneR, sfx_busy, sfx_id, sfx_done, e.tl, e.tr, e.busy, e.id, e.done);
      end
    end
  endtask

  // Duplicate id0 requests collapse; id2 arrives exactly on id1's final cycle and preempts it.
  task automatic test_back_to_back();
    exp_t e;
    push_effect(1, 16, 1'b0);
    push_effect(2, 24, 1'b1);
    push_effect(0, 24, 1'b1);
    push_idle(2);
    for (int c = 0; sb.size() > 0; c++) begin
      sfx_req = (c == 0) ? 4'b0010 : (c == 2 || c == 4) ? 4'b0001 : (c == 16) ? 4'b0100 : 4'b0000;
      @(posedge clk); #1;
      e = sb.pop_front(); n_checks++;
      if ({toneL, toneR, sfx_busy, sfx_id, sfx_done} !== e) begin
        n_fail++;
        $display("FAIL back_to_back c%0d: got tl=%0d tr=%0d busy=%0b id=%0d done=%0b, want tl=%0d tr=%0d busy=%0b id=%0d done=%0b",
                 c, toneL, toneR, sfx_busy, sfx_id, sfx_done, e.tl, e.tr, e.busy, e.id, e.done);
      end
    end
  endtask

  task automatic test_mute_reset();
    exp_t e;
    push_effect(2, 24, 1'b1);
    push_idle(4);
    push_effect(3, 12, 1'b0);
    src_l = REST; src_r = REST; done_next = 1'b0;
    push_state(1'b0, 2'd0, hz(bgm_l), hz(bgm_r));
    push_idle(10);
    mute_window(4, 26);
    for (int c = 0; sb.size() > 0; c++) begin
      sfx_req = (c == 0) ? 4'b0100 : (c == 28) ? 4'b1000 : (c == 30) ? 4'b0011 : 4'b0000;
      mute = (c >= 4 && c <= 26);
      rst = (c == 40);
      @(posedge clk); #1;
      e = sb.pop_front(); n_checks++;
      if ({toneL, toneR, sfx_busy, sfx_id, sfx_done} !== e) begin
        n_fail++;
        $display("FAIL mute_reset c%0d: got tl=%0d tr=%0d busy=%0b id=%0d done=%0b, want tl=%0d tr=%0d busy=%0b id=%0d done=%0b",
                 c, toneL, toneR, sfx_busy, sfx_id, sfx_done, e.tl, e.tr, e.busy, e.id, e.done);
      end
    end
    rst = 1'b0; mute = 1'b0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_single();
    test_preempt();
    test_queueing();
    test_back_to_back();
    test_mute_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
